// File: rtl/ponteh_ctrl.sv
// ponteh_ctrl: PWM H-bridge controller driven by a small register-write bus.
// A 2-bit register select (RGT) and a 2-bit value (VLR) program the rotation
// direction and the duty level. The block drives two bridge-leg enables:
// SH (clockwise) and SA (counter-clockwise).
// FR is an asynchronous brake input; it is synchronised and forces both legs off.
// Optional feature macro: PONTEH_DEADTIME_EN. When defined, a change of direction
// inserts DEAD_CYCLES cycles with both legs off. When undefined, a direction
// change takes effect on the next edge.
module ponteh_ctrl #(
  parameter int PWM_STEP    = 1,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] RGT,
  input  logic [1:0] VLR,
  input  logic       FR,
  output logic       SA,
  output logic       SH
);

  localparam int PERIOD = 3 * PWM_STEP;
  localparam int CW     = $clog2(PERIOD);
  localparam int TW     = CW + 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [3:0]    DEAD_LOAD = 4'(DEAD_CYCLES);

  localparam logic [1:0] REG_NONE = 2'b00;
  localparam logic [1:0] REG_DIR  = 2'b01;
  localparam logic [1:0] REG_DUTY = 2'b10;
  localparam logic [1:0] REG_STOP = 2'b11;

  localparam logic [1:0] DIR_CW  = 2'b01;
  localparam logic [1:0] DIR_CCW = 2'b10;

  logic [1:0]    dir_r;
  logic [1:0]    duty_r;
  logic [CW-1:0] cnt_r;
  logic          brk_meta_r;
  logic          brk_sync_r;
  logic          sa_r;
  logic          sh_r;

  logic [1:0]    dir_n_s;
  logic [1:0]    duty_n_s;
  logic          dir_wr_s;
  logic [TW-1:0] thr_s;
  logic          pwm_on_s;
  logic          dead_ok_s;

  // Decode the bus write into the post-write register values used by this edge
  always_comb begin
    dir_n_s  = dir_r;
    duty_n_s = duty_r;
    dir_wr_s = 1'b0;
    case (RGT)
      REG_NONE: begin
        dir_n_s  = dir_r;
        duty_n_s = duty_r;
      end
      REG_DIR: begin
        dir_n_s  = VLR;
        dir_wr_s = 1'b1;
      end
      REG_DUTY: begin
        duty_n_s = VLR;
      end
      REG_STOP: begin
        dir_n_s  = 2'b00;
        duty_n_s = 2'b00;
      end
      default: begin
        dir_n_s  = dir_r;
        duty_n_s = duty_r;
      end
    endcase
  end

  // PWM comparison against the new duty so a duty write acts on the same edge
  always_comb begin
    thr_s    = TW'(duty_n_s) * TW'(PWM_STEP);
    pwm_on_s = (TW'(cnt_r) < thr_s);
  end

  // Direction and duty registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_r  <= 2'b00;
      duty_r <= 2'b00;
    end else begin
      dir_r  <= dir_n_s;
      duty_r <= duty_n_s;
    end
  end

  // Free-running PWM counter; writes never realign the period
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous brake request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      brk_meta_r <= 1'b0;
      brk_sync_r <= 1'b0;
    end else begin
      brk_meta_r <= FR;
      brk_sync_r <= brk_meta_r;
    end
  end

`ifdef PONTEH_DEADTIME_EN
  logic [3:0] dead_r;
  logic [3:0] dead_n_s;

  // Dead-time reload on a real direction change, otherwise count down to zero
  always_comb begin
    dead_n_s = dead_r;
    if (dir_wr_s && (VLR != dir_r)) begin
      dead_n_s = DEAD_LOAD;
    end else if (dead_r != 4'd0) begin
      dead_n_s = dead_r - 4'd1;
    end else begin
      dead_n_s = 4'd0;
    end
  end

  // Dead-time counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dead_r <= 4'd0;
    end else begin
      dead_r <= dead_n_s;
    end
  end

  assign dead_ok_s = (dead_n_s == 4'd0);
`else
  logic unused_dead_s;
  logic unused_dirwr_s;

  assign unused_dead_s  = ^DEAD_LOAD;
  assign unused_dirwr_s = dir_wr_s;
  assign dead_ok_s      = 1'b1;
`endif

  // Registered leg enables; a single DIR value keeps the legs mutually exclusive
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_r <= 1'b0;
      sa_r <= 1'b0;
    end else begin
      sh_r <= (dir_n_s == DIR_CW)  & pwm_on_s & ~brk_sync_r & dead_ok_s;
      sa_r <= (dir_n_s == DIR_CCW) & pwm_on_s & ~brk_sync_r & dead_ok_s;
    end
  end

  assign SH = sh_r;
  assign SA = sa_r;

endmodule

// File: tb/tb_ponteh_ctrl.sv
// Self-checking bench for ponteh_ctrl with a cycle-level reference model.
module tb_ponteh_ctrl;

  localparam int STEP   = 2;
  localparam int DEAD   = 2;
  localparam int PERIOD = 3 * STEP;

  logic       CLK;
  logic       RST;
  logic [1:0] RGT;
  logic [1:0] VLR;
  logic       FR;
  logic       SA;
  logic       SH;

  int checks;
  int failures;

  // reference model state
  int m_dir, m_duty, m_dead, m_phase;
  bit fr_d1, fr_d2;
  bit exp_sa, exp_sh;

  ponteh_ctrl #(.PWM_STEP(STEP), .DEAD_CYCLES(DEAD)) dut (
    .CLK(CLK), .RST(RST), .RGT(RGT), .VLR(VLR), .FR(FR), .SA(SA), .SH(SH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_dir = 0; m_duty = 0; m_dead = 0; m_phase = 0;
    fr_d1 = 1'b0; fr_d2 = 1'b0;
    exp_sa = 1'b0; exp_sh = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] rgt, input logic [1:0] vlr, input logic fr);
    int old_dir;
    bit brk, on;
    old_dir = m_dir;
    case (rgt)
      2'b01: m_dir = int'(vlr);
      2'b10: m_duty = int'(vlr);
      2'b11: begin m_dir = 0; m_duty = 0; end
      default: ;
    endcase
`ifdef PONTEH_DEADTIME_EN
    if (rgt == 2'b01 && int'(vlr) != old_dir) m_dead = DEAD;
    else if (m_dead > 0) m_dead = m_dead - 1;
`endif
    brk = fr_d2;
    fr_d2 = fr_d1;
    fr_d1 = fr;
    on = (m_phase < m_duty * STEP);
    exp_sh = (m_dir == 1) && on && !brk && (m_dead == 0);
    exp_sa = (m_dir == 2) && on && !brk && (m_dead == 0);
    m_phase = (m_phase + 1) % PERIOD;
  endtask

  task automatic step(input logic [1:0] rgt, input logic [1:0] vlr, input logic fr);
    RGT = rgt; VLR = vlr; FR = fr;
    @(posedge CLK);
    model_edge(rgt, vlr, fr);
    #1;
  endtask

  task automatic assert_rst();
    RST = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_rst(input int n);
    repeat (n) begin @(posedge CLK); #1; end
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RGT = 2'b01; VLR = 2'b01; FR = 1'b0;
    assert_rst();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (SA !== 1'b0 || SH !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got SA=%b SH=%b exp SA=0 SH=0", i, SA, SH);
      end
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 2'b00, 1'b0);
      checks++;
      if (SA !== 1'b0 || SH !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got SA=%b SH=%b exp SA=0 SH=0", i, SA, SH);
      end
    end
  endtask

  task automatic test_full_drive();
    step(2'b01, 2'b01, 1'b0);
    step(2'b10, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(2'b00, 2'b00, 1'b0);
      checks++;
      if ({SA, SH} !== {exp_sa, exp_sh}) begin
        failures++;
        $display("FAIL full_drive cyc=%0d got SA=%b SH=%b exp SA=%b SH=%b", i, SA, SH, exp_sa, exp_sh);
      end
    end
    checks++;
    if (SH !== 1'b1 || SA !== 1'b0) begin
      failures++;
      $display("FAIL full_drive_const got SA=%b SH=%b exp SA=0 SH=1", SA, SH);
    end
  endtask

  task automatic test_duty();
    int highs;
    logic [1:0] d;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
      highs = 0;
      for (int i = 0; i < PERIOD; i++) begin
        if (i == 0) step(2'b10, d, 1'b0);
        else step(2'b00, 2'b00, 1'b0);
        if (SH === 1'b1) highs++;
        checks++;
        if ({SA, SH} !== {exp_sa, exp_sh}) begin
          failures++;
          $display("FAIL duty_cycle d=%0d cyc=%0d got SA=%b SH=%b exp SA=%b SH=%b", d, i, SA, SH, exp_sa, exp_sh);
        end
      end
      checks++;
      if (highs != int'(d) * STEP) begin
        failures++;
        $display("FAIL duty_count d=%0d got highs=%0d exp highs=%0d", d, highs, int'(d) * STEP);
      end
    end
  endtask

  task automatic test_reversal();
    logic [2:0] seq;
`ifdef PONTEH_DEADTIME_EN
    seq = 3'b100;
`else
    seq = 3'b111;
`endif
    step(2'b01, 2'b01, 1'b0);
    step(2'b10, 2'b11, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(2'b01, 2'b10, 1'b0);
      else step(2'b00, 2'b00, 1'b0);
      checks++;
      if (SH !== 1'b0 || SA !== seq[i] || {SA, SH} !== {exp_sa, exp_sh}) begin
        failures++;
        $display("FAIL reversal cyc=%0d got SA=%b SH=%b exp SA=%b SH=0", i, SA, SH, seq[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 2'b10, 1'b0);
      checks++;
      if (SA !== 1'b1 || SH !== 1'b0) begin
        failures++;
        $display("FAIL rewrite_nogap cyc=%0d got SA=%b SH=%b exp SA=1 SH=0", i, SA, SH);
      end
    end
  endtask

  task automatic test_brake();
    step(2'b01, 2'b01, 1'b0);
    step(2'b10, 2'b11, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) step(2'b10, 2'b01, 1'b1);
      else step(2'b00, 2'b00, 1'b1);
      checks++;
      if ({SA, SH} !== {exp_sa, exp_sh}) begin
        failures++;
        $display("FAIL brake_on cyc=%0d got SA=%b SH=%b exp SA=%b SH=%b", i, SA, SH, exp_sa, exp_sh);
      end
      if (i >= 2) begin
        checks++;
        if (SH !== 1'b0) begin
          failures++;
          $display("FAIL brake_latency cyc=%0d got SH=%b exp SH=0", i, SH);
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 2'b00, 1'b0);
      checks++;
      if ({SA, SH} !== {exp_sa, exp_sh}) begin
        failures++;
        $display("FAIL brake_release cyc=%0d got SA=%b SH=%b exp SA=%b SH=%b", i, SA, SH, exp_sa, exp_sh);
      end
    end
  endtask

  task automatic test_soft_stop();
    step(2'b01, 2'b10, 1'b0);
    step(2'b10, 2'b11, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0);
    checks++;
    if (SA !== 1'b1) begin
      failures++;
      $display("FAIL soft_stop_pre got SA=%b exp SA=1", SA);
    end
    step(2'b11, 2'($urandom_range(3, 0)), 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(2'b00, 2'b00, 1'b0);
      checks++;
      if (SA !== 1'b0 || SH !== 1'b0 || m_dir != 0 || m_duty != 0) begin
        failures++;
        $display("FAIL soft_stop cyc=%0d got SA=%b SH=%b exp SA=0 SH=0", i, SA, SH);
      end
    end
  endtask

  task automatic test_random();
    logic fr;
    fr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7, 0) == 0) fr = ~fr;
      step(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), fr);
      checks++;
      if ({SA, SH} !== {exp_sa, exp_sh}) begin
        failures++;
        $display("FAIL random cyc=%0d got SA=%b SH=%b exp SA=%b SH=%b", i, SA, SH, exp_sa, exp_sh);
      end
      checks++;
      if ((SA & SH) !== 1'b0) begin
        failures++;
        $display("FAIL exclusive cyc=%0d got SA=%b SH=%b exp not both 1", i, SA, SH);
      end
      if (i % 150 == 149) begin
        assert_rst();
        checks++;
        if (SA !== 1'b0 || SH !== 1'b0) begin
          failures++;
          $display("FAIL async_reset cyc=%0d got SA=%b SH=%b exp SA=0 SH=0", i, SA, SH);
        end
        fr = 1'b0;
        FR = 1'b0;
        release_rst(2);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b1; RGT = 2'b00; VLR = 2'b00; FR = 1'b0;
    model_reset();
    test_reset();
    test_full_drive();
    test_duty();
    test_reversal();
    test_brake();
    test_soft_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
